// File: rtl/sc_io_pkg.sv
// Shared constants and address decode helpers for the sc_io_ports register window.
package sc_io_pkg;

  localparam logic [7:0] IO_IN_BASE   = 8'h00;
  localparam logic [7:0] IO_OUT_BASE  = 8'h40;
  localparam logic [7:0] IO_STATUS    = 8'h80;
  localparam logic [7:0] IO_MASK      = 8'h84;
  localparam int         IO_MAX_PORTS = 16;
  localparam int         IDX_W        = $clog2(IO_MAX_PORTS);

  typedef enum logic [2:0] {
    RegNone,
    RegIn,
    RegOut,
    RegStatus,
    RegMask
  } io_region_e;

  // Decodes a word address; the byte lane bits are dropped by the caller.
  function automatic io_region_e decodeRegion(input logic [5:0] word);
    if (word == IO_STATUS[7:2])          return RegStatus;
    if (word == IO_MASK[7:2])            return RegMask;
    if (word[5:4] == IO_IN_BASE[7:6])    return RegIn;
    if (word[5:4] == IO_OUT_BASE[7:6])   return RegOut;
    return RegNone;
  endfunction

  function automatic logic [IDX_W-1:0] wordIndex(input logic [5:0] word);
    return word[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/sc_io_ports_if.sv
// CPU-side register bus of the I/O window; the CPU is the master.
interface sc_io_ports_if #(
  parameter int WIDTH = 32
);
  logic             io_sel;
  logic             we;
  logic [7:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output io_sel, we, addr, wdata, input rdata);
  modport slave  (input io_sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/sc_io_sync.sv
// One input channel: two-flop synchroniser, previous-value register and a
// sticky change flag that is write-1-to-clear, with set taking priority.
module sc_io_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             armed_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] syncVal_o,
  output logic             flag_o,
  output logic             flagNext_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] prev_q;
  logic             flag_q;
  logic             flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clear_i)                     flag_d = 1'b0;
    if (armed_i && (s2_q != prev_q)) flag_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      flag_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      flag_q <= flag_d;
    end
  end

  assign syncVal_o  = s2_q;
  assign flag_o     = flag_q;
  assign flagNext_o = flag_d;

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O unit: N_IN synchronised inputs with change flags and a
// maskable interrupt, N_OUT registered outputs, one word-addressed window.
module sc_io_ports
  import sc_io_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  sc_io_ports_if.slave           bus,
  input  logic [N_IN*WIDTH-1:0]  in_port,
  output logic [N_OUT*WIDTH-1:0] out_port,
  output logic                   irq
);

  logic [1:0]                   warm_q, warm_d;
  logic [N_OUT-1:0][WIDTH-1:0]  out_q, out_d;
  logic [N_IN-1:0]              mask_q, mask_d;
  logic                         irq_q, irq_d;
  logic [N_IN-1:0][WIDTH-1:0]   inSync;
  logic [N_IN-1:0]              status;
  logic [N_IN-1:0]              statusNext;
  logic [N_IN-1:0]              clear;
  logic                         armed;
  logic                         wr;
  io_region_e                   region;
  logic [IDX_W-1:0]             idx;
  logic [WIDTH-1:0]             rdataC;
  logic                         unusedAddrBits;

  assign region         = decodeRegion(bus.addr[7:2]);
  assign idx            = wordIndex(bus.addr[7:2]);
  assign wr             = bus.io_sel & bus.we;
  assign unusedAddrBits = ^bus.addr[1:0];

  // Warm-up counter keeps change detection off until the pipeline holds real samples.
  assign armed  = (warm_q == 2'd3);
  assign warm_d = armed ? warm_q : warm_q + 2'd1;

  for (genvar g = 0; g < N_IN; g++) begin : gen_in
    sc_io_sync #(.WIDTH(WIDTH)) u_sync (
      .clock      (clock),
      .resetn     (resetn),
      .armed_i    (armed),
      .clear_i    (clear[g]),
      .din_i      (in_port[g*WIDTH +: WIDTH]),
      .syncVal_o  (inSync[g]),
      .flag_o     (status[g]),
      .flagNext_o (statusNext[g])
    );
  end

  always_comb begin
    clear  = '0;
    mask_d = mask_q;
    out_d  = out_q;
    if (wr && region == RegStatus) clear  = bus.wdata[N_IN-1:0];
    if (wr && region == RegMask)   mask_d = bus.wdata[N_IN-1:0];
    if (wr && region == RegOut) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (idx == IDX_W'(i)) out_d[i] = bus.wdata;
      end
    end
  end

  assign irq_d = |(statusNext & mask_d);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      warm_q <= 2'd0;
      out_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      warm_q <= warm_d;
      out_q  <= out_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  // Indices beyond the configured port count fall through and read 0.
  always_comb begin
    rdataC = '0;
    case (region)
      RegIn: begin
        for (int i = 0; i < N_IN; i++) begin
          if (idx == IDX_W'(i)) rdataC = inSync[i];
        end
      end
      RegOut: begin
        for (int i = 0; i < N_OUT; i++) begin
          if (idx == IDX_W'(i)) rdataC = out_q[i];
        end
      end
      RegStatus: rdataC[N_IN-1:0] = status;
      RegMask:   rdataC[N_IN-1:0] = mask_q;
      default:   rdataC = '0;
    endcase
  end

  assign bus.rdata = rdataC;
  assign out_port  = out_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sc_io_ports.sv
// Self-checking bench for sc_io_ports: history-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sc_io_ports;

  localparam int W  = 32;
  localparam int NI = 4;
  localparam int NO = 4;

  typedef logic [NI*W-1:0] inVec_t;

  logic           clock;
  logic           resetn;
  inVec_t         inPort;
  logic [NO*W-1:0] outPort;
  logic           irq;

  int compared   = 0;
  int mismatched = 0;

  sc_io_ports_if #(.WIDTH(W)) bus ();

  sc_io_ports #(.WIDTH(W), .N_IN(NI), .N_OUT(NO)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .in_port  (inPort),
    .out_port (outPort),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: outputs derived from the sampled input history and the register map.
  logic [W-1:0]  mOut [NO];
  logic [NI-1:0] mStatus = '0;
  logic [NI-1:0] mMask   = '0;
  logic          mIrq    = 1'b0;
  int            mEdges  = 0;
  inVec_t        mHist [$];

  initial for (int i = 0; i < NO; i++) mOut[i] = '0;

  function automatic logic [W-1:0] mInVal(input int port);
    inVec_t v;
    if (mHist.size() < 2) return '0;
    v = mHist[1];
    return v[port*W +: W];
  endfunction

  function automatic logic [W-1:0] modelRead(input logic [7:0] a);
    int ix;
    ix = int'(a[5:2]);
    if (a[7:2] == 6'h20) return W'(mStatus);
    if (a[7:2] == 6'h21) return W'(mMask);
    if (a[7:6] == 2'b00) return (ix < NI) ? mInVal(ix) : '0;
    if (a[7:6] == 2'b01) return (ix < NO) ? mOut[ix] : '0;
    return '0;
  endfunction

  always @(posedge clock or negedge resetn) begin
    logic [NI-1:0] setV;
    logic [NI-1:0] clrV;
    inVec_t        newer;
    inVec_t        older;
    int            ix;
    if (!resetn) begin
      mStatus = '0;
      mMask   = '0;
      mIrq    = 1'b0;
      mEdges  = 0;
      mHist.delete();
      for (int i = 0; i < NO; i++) mOut[i] = '0;
    end else begin
      mEdges++;
      setV = '0;
      clrV = '0;
      // A flag needs a sample pair seen two and three edges back, taken after warm-up.
      if (mEdges >= 4) begin
        newer = mHist[1];
        older = mHist[2];
        for (int i = 0; i < NI; i++)
          if (newer[i*W +: W] != older[i*W +: W]) setV[i] = 1'b1;
      end
      if (bus.io_sel && bus.we) begin
        ix = int'(bus.addr[5:2]);
        if (bus.addr[7:2] == 6'h20)      clrV  = bus.wdata[NI-1:0];
        else if (bus.addr[7:2] == 6'h21) mMask = bus.wdata[NI-1:0];
        else if (bus.addr[7:6] == 2'b01 && ix < NO) mOut[ix] = bus.wdata;
      end
      mStatus = setV | (mStatus & ~clrV);
      mIrq    = |(mStatus & mMask);
      mHist.push_front(inPort);
      if (mHist.size() > 3) void'(mHist.pop_back());
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("rdata_vs_model", bus.rdata, modelRead(bus.addr));
    for (int i = 0; i < NO; i++)
      checkOutput($sformatf("out_port%0d_vs_model", i), outPort[i*W +: W], mOut[i]);
    checkOutput("irq_vs_model", W'(irq), W'(mIrq));
  end

  task automatic applyStimulus(input logic sel, input logic wen, input logic [7:0] a, input logic [W-1:0] d);
    bus.io_sel = sel;
    bus.we     = wen;
    bus.addr   = a;
    bus.wdata  = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [W-1:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    tick(1);
    applyStimulus(1'b0, 1'b0, a, '0);
  endtask

  task automatic busRead(input logic [7:0] a, output logic [W-1:0] d);
    applyStimulus(1'b1, 1'b0, a, '0);
    #1;
    d = bus.rdata;
    applyStimulus(1'b0, 1'b0, a, '0);
  endtask

  initial begin
    logic [W-1:0] d;
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, '0);
    inPort = '0;
    inPort[0*W +: W] = 32'h22222222;
    inPort[2*W +: W] = 32'h88888888;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;

    // Level present at reset is visible but never flagged.
    tick(5);
    busRead(8'h00, d); checkOutput("in0_after_reset", d, 32'h22222222);
    busRead(8'h80, d); checkOutput("status_after_reset", d, 32'h0);
    checkOutput("irq_after_reset", W'(irq), 32'h0);

    busWrite(8'h44, 32'h55555555);
    checkOutput("out1_after_write", outPort[1*W +: W], 32'h55555555);
    checkOutput("out0_untouched", outPort[0*W +: W], 32'h0);
    busRead(8'h44, d); checkOutput("out1_readback", d, 32'h55555555);
    busRead(8'h47, d); checkOutput("out1_byte_lane_ignored", d, 32'h55555555);

    // Change on port 2 with its mask bit set.
    busWrite(8'h84, 32'h4);
    inPort[2*W +: W] = 32'hffffffff;
    tick(1);
    busRead(8'h08, d); checkOutput("in2_old_after_k", d, 32'h88888888);
    tick(1);
    busRead(8'h08, d); checkOutput("in2_new_after_k1", d, 32'hffffffff);
    busRead(8'h80, d); checkOutput("status_clear_after_k1", d, 32'h0);
    checkOutput("irq_low_after_k1", W'(irq), 32'h0);
    tick(1);
    busRead(8'h80, d); checkOutput("status_set_after_k2", d, 32'h4);
    checkOutput("irq_set_after_k2", W'(irq), 32'h1);
    busWrite(8'h80, 32'h4);
    busRead(8'h80, d); checkOutput("status_w1c", d, 32'h0);
    checkOutput("irq_w1c", W'(irq), 32'h0);

    // W1C on the same edge that a new change sets the flag.
    inPort[2*W +: W] = 32'h12345678;
    tick(3);
    busRead(8'h80, d); checkOutput("status_reset_again", d, 32'h4);
    inPort[2*W +: W] = 32'habcdef01;
    tick(2);
    applyStimulus(1'b1, 1'b1, 8'h80, 32'h4);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h80, '0);
    busRead(8'h80, d); checkOutput("set_beats_clear", d, 32'h4);
    checkOutput("irq_set_beats_clear", W'(irq), 32'h1);
    busWrite(8'h80, 32'h4);
    busRead(8'h80, d); checkOutput("status_cleared_again", d, 32'h0);

    // Masked-off flag, then a mask write raises irq on that edge.
    busWrite(8'h84, 32'h0);
    inPort[1*W +: W] = 32'h000000a5;
    tick(3);
    busRead(8'h80, d); checkOutput("status_bit1_masked", d, 32'h2);
    checkOutput("irq_masked_off", W'(irq), 32'h0);
    busWrite(8'h84, 32'h2);
    checkOutput("irq_after_mask_write", W'(irq), 32'h1);
    busRead(8'h84, d); checkOutput("mask_readback", d, 32'h2);

    // Unmapped offsets and ignored writes.
    busRead(8'h3c, d); checkOutput("in15_reads_zero", d, 32'h0);
    busRead(8'h90, d); checkOutput("unmapped_0x90", d, 32'h0);
    busRead(8'h88, d); checkOutput("unmapped_0x88", d, 32'h0);
    busWrite(8'h50, 32'hdeadbeef);
    busRead(8'h50, d); checkOutput("out4_reads_zero", d, 32'h0);
    busWrite(8'h00, 32'h11111111);
    busRead(8'h00, d); checkOutput("in0_write_ignored", d, 32'h22222222);
    busWrite(8'h88, 32'hf);
    busRead(8'h84, d); checkOutput("mask_after_0x88_write", d, 32'h2);

    // Asynchronous reset mid-run with outputs and a flag set.
    resetn = 1'b0;
    #1;
    checkOutput("out1_async_reset", outPort[1*W +: W], 32'h0);
    checkOutput("irq_async_reset", W'(irq), 32'h0);
    busRead(8'h44, d); checkOutput("out1_read_in_reset", d, 32'h0);
    busRead(8'h80, d); checkOutput("status_in_reset", d, 32'h0);
    busRead(8'h84, d); checkOutput("mask_in_reset", d, 32'h0);
    busRead(8'h00, d); checkOutput("in0_in_reset", d, 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(6);
    busRead(8'h80, d); checkOutput("no_flag_after_rerelease", d, 32'h0);
    checkOutput("irq_after_rerelease", W'(irq), 32'h0);
    busRead(8'h04, d); checkOutput("in1_after_rerelease", d, 32'h000000a5);
    busRead(8'h08, d); checkOutput("in2_after_rerelease", d, 32'habcdef01);

    tick(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
